// File: rtl/sd_cmd_master.sv
// sd_cmd_master: sequences one SD command on the serial host, captures the response and raises status flags.
module sd_cmd_master #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 sd_clk_tick_i,
  input  logic                 soft_rst_i,
  input  logic                 cmd_start_i,
  input  logic [31:0]          argument_i,
  input  logic [13:0]          command_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 int_rst_i,
  output logic [39:0]          host_cmd_o,
  output logic [1:0]           host_setting_o,
  output logic                 host_start_o,
  output logic                 host_abort_o,
  input  logic                 host_finish_i,
  input  logic                 host_crc_ok_i,
  input  logic                 host_index_ok_i,
  input  logic [119:0]         host_resp_i,
  output logic [31:0]          response_0_o,
  output logic [31:0]          response_1_o,
  output logic [31:0]          response_2_o,
  output logic [31:0]          response_3_o,
  output logic [4:0]           int_status_o,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, SETUP, EXECUTE, FINISH} state_t;
  state_t state, state_nxt;
  logic [1:0] chk_q;
  logic [TIMEOUT_W-1:0] to_q, cnt;
  logic start_ok, fin, tmo, has_resp, crc_err, idx_err;
  logic [4:0] set_bits;
  always_comb begin
    start_ok  = !soft_rst_i && state == IDLE && cmd_start_i;
    fin       = !soft_rst_i && state == EXECUTE && host_finish_i;
    tmo       = !soft_rst_i && state == EXECUTE && !host_finish_i && to_q != '0 && cnt == to_q;
    has_resp  = host_setting_o != 2'b00;
    crc_err   = chk_q[0] && has_resp && !host_crc_ok_i;
    idx_err   = chk_q[1] && has_resp && !host_index_ok_i;
    set_bits  = fin ? {idx_err, crc_err, 1'b0, idx_err | crc_err, 1'b1} : tmo ? 5'b00110 : 5'b00000;
    state_nxt = soft_rst_i ? IDLE :
                start_ok ? SETUP :
                state == SETUP ? EXECUTE :
                (fin || tmo) ? FINISH :
                state == FINISH ? IDLE : state;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      host_start_o   <= 1'b0;
      host_abort_o   <= 1'b0;
      host_cmd_o     <= '0;
      host_setting_o <= '0;
      chk_q          <= '0;
      to_q           <= '0;
      cnt            <= '0;
      int_status_o   <= '0;
      response_0_o   <= '0;
      response_1_o   <= '0;
      response_2_o   <= '0;
      response_3_o   <= '0;
    end else begin
      state        <= state_nxt;
      busy_o       <= state_nxt != IDLE;
      host_start_o <= start_ok;
      host_abort_o <= tmo;
      if (start_ok) begin
        host_cmd_o     <= {2'b01, command_i[13:8], argument_i};
        host_setting_o <= command_i[1:0];
        chk_q          <= command_i[4:3];
        to_q           <= timeout_i;
      end
      cnt <= (soft_rst_i || state == SETUP) ? '0 :
             (state == EXECUTE && sd_clk_tick_i) ? cnt + 1'b1 : cnt;
      // a same-cycle set survives the interrupt clear
      int_status_o <= soft_rst_i ? 5'b00000 : ((int_rst_i ? 5'b00000 : int_status_o) | set_bits);
      if (soft_rst_i) begin
        response_0_o <= '0;
        response_1_o <= '0;
        response_2_o <= '0;
        response_3_o <= '0;
      end else if (fin && has_resp) begin
        response_0_o <= host_resp_i[119:88];
        if (host_setting_o == 2'b10) begin
          response_1_o <= host_resp_i[87:56];
          response_2_o <= host_resp_i[55:24];
          response_3_o <= {host_resp_i[23:0], 8'h00};
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_cmd_master.sv
// tb_sd_cmd_master: directed-vector bench for the SD command sequencer.
module tb_sd_cmd_master;
  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         sd_clk_tick_i = 1'b0;
  logic         soft_rst_i = 1'b0;
  logic         cmd_start_i = 1'b0;
  logic [31:0]  argument_i = '0;
  logic [13:0]  command_i = '0;
  logic [15:0]  timeout_i = '0;
  logic         int_rst_i = 1'b0;
  logic [39:0]  host_cmd_o;
  logic [1:0]   host_setting_o;
  logic         host_start_o;
  logic         host_abort_o;
  logic         host_finish_i = 1'b0;
  logic         host_crc_ok_i = 1'b1;
  logic         host_index_ok_i = 1'b1;
  logic [119:0] host_resp_i = '0;
  logic [31:0]  response_0_o, response_1_o, response_2_o, response_3_o;
  logic [4:0]   int_status_o;
  logic         busy_o;
  int n_cmp = 0;
  int n_err = 0;

  sd_cmd_master #(.TIMEOUT_W(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .sd_clk_tick_i(sd_clk_tick_i),
    .soft_rst_i(soft_rst_i), .cmd_start_i(cmd_start_i), .argument_i(argument_i),
    .command_i(command_i), .timeout_i(timeout_i), .int_rst_i(int_rst_i),
    .host_cmd_o(host_cmd_o), .host_setting_o(host_setting_o), .host_start_o(host_start_o),
    .host_abort_o(host_abort_o), .host_finish_i(host_finish_i), .host_crc_ok_i(host_crc_ok_i),
    .host_index_ok_i(host_index_ok_i), .host_resp_i(host_resp_i),
    .response_0_o(response_0_o), .response_1_o(response_1_o), .response_2_o(response_2_o),
    .response_3_o(response_3_o), .int_status_o(int_status_o), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_start(input logic [31:0] arg, input logic [13:0] cmd, input logic [15:0] to, input logic [39:0] exp_cmd);
    argument_i  = arg;
    command_i   = cmd;
    timeout_i   = to;
    cmd_start_i = 1'b1;
    step();
    cmd_start_i = 1'b0;
    check("start_pulse", host_start_o, 1);
    check("busy_rise", busy_o, 1);
    check("host_cmd", host_cmd_o, exp_cmd);
    check("host_setting", host_setting_o, cmd[1:0]);
    step();
    check("start_one_cycle", host_start_o, 0);
  endtask

  task automatic do_finish(input logic [119:0] resp, input logic crc, input logic idx, input logic ir);
    host_resp_i     = resp;
    host_crc_ok_i   = crc;
    host_index_ok_i = idx;
    host_finish_i   = 1'b1;
    int_rst_i       = ir;
    step();
    host_finish_i   = 1'b0;
    int_rst_i       = 1'b0;
  endtask

  task automatic clear_int();
    int_rst_i = 1'b1;
    step();
    int_rst_i = 1'b0;
    check("int_clear", int_status_o, 0);
  endtask

  initial begin
    int n_ab, at;
    logic [4:0] st;
    step();
    step();
    wb_rst_i = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_cmd", host_cmd_o, 0);
    check("rst_status", int_status_o, 0);
    check("rst_resp0", response_0_o, 0);
    check("rst_pulses", {host_start_o, host_abort_o}, 0);
    step();
    // short response, both checks pass
    do_start(32'h000001AA, 14'h0819, 16'd0, 40'h48000001AA);
    do_finish({32'h000001AA, 88'h0}, 1'b1, 1'b1, 1'b0);
    check("short_resp0", response_0_o, 32'h000001AA);
    check("short_status", int_status_o, 5'b00001);
    check("finish_busy", busy_o, 1);
    step();
    check("busy_fall", busy_o, 0);
    clear_int();
    // long response
    do_start(32'h0, 14'h0002, 16'd0, 40'h4000000000);
    do_finish(120'hAABBCCDD_11223344_55667788_99AABB, 1'b1, 1'b1, 1'b0);
    check("long_r0", response_0_o, 32'hAABBCCDD);
    check("long_r1", response_1_o, 32'h11223344);
    check("long_r2", response_2_o, 32'h55667788);
    check("long_r3", response_3_o, 32'h99AABB00);
    check("long_status", int_status_o, 5'b00001);
    step();
    clear_int();
    // timeout of 5 ticks, no finish
    sd_clk_tick_i = 1'b1;
    do_start(32'h0, 14'h0101, 16'd5, 40'h4100000000);
    n_ab = 0;
    at = 0;
    st = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (host_abort_o) begin
        n_ab++;
        at = i;
        st = int_status_o;
      end
    end
    sd_clk_tick_i = 1'b0;
    check("abort_count", n_ab, 1);
    check("abort_cycle", at, 6);
    check("timeout_status", st, 5'b00110);
    check("timeout_busy", busy_o, 0);
    clear_int();
    // CRC and index errors on a short response
    do_start(32'h00000000, 14'h0819, 16'd0, 40'h4800000000);
    do_finish({32'hCAFEF00D, 88'h0}, 1'b0, 1'b0, 1'b0);
    check("err_status", int_status_o, 5'b11011);
    check("short_keeps_r1", response_1_o, 32'h11223344);
    step();
    // checks disabled, with interrupt clear colliding with the set
    do_start(32'h00000000, 14'h0801, 16'd0, 40'h4800000000);
    do_finish({32'hCAFEF00D, 88'h0}, 1'b0, 1'b0, 1'b1);
    check("collision_status", int_status_o, 5'b00001);
    step();
    clear_int();
    // start while busy is ignored; type 00 keeps responses
    do_start(32'h12345678, 14'h0C00, 16'd0, 40'h4C12345678);
    argument_i  = 32'h87654321;
    command_i   = 14'h0D01;
    cmd_start_i = 1'b1;
    step();
    cmd_start_i = 1'b0;
    check("busy_start_pulse", host_start_o, 0);
    check("busy_start_cmd", host_cmd_o, 40'h4C12345678);
    do_finish({120{1'b1}}, 1'b0, 1'b0, 1'b0);
    check("none_keeps_r0", response_0_o, 32'hCAFEF00D);
    check("none_status", int_status_o, 5'b00001);
    step();
    check("no_restart", {host_start_o, busy_o}, 0);
    // soft reset mid-EXECUTE
    do_start(32'h1, 14'h0002, 16'd0, 40'h4000000001);
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    check("soft_busy", busy_o, 0);
    check("soft_status", int_status_o, 0);
    check("soft_resp", {response_0_o, response_1_o, response_2_o, response_3_o}, 0);
    do_finish(120'h1, 1'b1, 1'b1, 1'b0);
    check("finish_ignored", int_status_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
